branch_resolve_queue: RTL and testbench

// - Holds in-flight branch predictions in order until each branch resolves.
// - Sits downstream of the 2-bit saturating-counter predictor: it captures each
//   `prediction` and later compares it with the actual outcome.
// - Generates the predictor's update strobe (`result`) and direction (`taken`).
// - Flags mispredictions and, optionally, keeps hit/miss statistics.

---
 rtl/branch_resolve_queue_if.sv | 31 +++
 rtl/branch_resolve_queue.sv | 82 ++++++++
 tb/tb_branch_resolve_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between the branch predictor front end and the branch resolve queue.
// The slave side is the queue; the master side is whoever pushes predictions and resolves branches.
interface branch_resolve_queue_if #(
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic             pred_bit;
  logic             pred_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             upd_valid;
  logic             upd_taken;
  logic             mispredict;
  logic             resolve_err;
  logic [PTR_W:0]   occupancy;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output pred_valid, pred_bit, resolve_valid, resolve_taken,
    input  pred_ready, upd_valid, upd_taken, mispredict, resolve_err,
           occupancy, total_cnt, miss_cnt
  );

  modport slave (
    input  pred_valid, pred_bit, resolve_valid, resolve_taken,
    output pred_ready, upd_valid, upd_taken, mispredict, resolve_err,
           occupancy, total_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branch directions; compares each against its resolved outcome.
// Define BRQ_STATS_EN to build saturating hit/miss statistics counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  branch_resolve_queue_if.slave brq
);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_OCC  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   occ;
  logic             push;
  logic             pop;
  logic             empty;

  assign empty          = (occ == '0);
  assign brq.pred_ready = (occ != FULL_OCC);
  assign brq.occupancy  = occ;
  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
  assign push = brq.pred_valid && brq.pred_ready && !flush;
  assign pop  = brq.resolve_valid && !empty && !flush;

  // Storage needs no reset; only entries between rptr and wptr are ever read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= brq.pred_bit;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr            <= '0;
      rptr            <= '0;
      occ             <= '0;
      brq.upd_valid   <= 1'b0;
      brq.mispredict  <= 1'b0;
      brq.resolve_err <= 1'b0;
      if (rst) brq.upd_taken <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ONE_PTR;
      if (pop)  rptr <= rptr + ONE_PTR;
      case ({push, pop})
        2'b10:   occ <= occ + ONE_OCC;
        2'b01:   occ <= occ - ONE_OCC;
        default: occ <= occ;
      endcase
      brq.upd_valid   <= pop;
      brq.mispredict  <= pop && (mem[rptr] != brq.resolve_taken);
      brq.resolve_err <= brq.resolve_valid && empty;
      if (pop) brq.upd_taken <= brq.resolve_taken;
    end
  end

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] miss_q;

  // Flush keeps the statistics; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      miss_q  <= '0;
    end else if (pop) begin
      if (total_q != '1) total_q <= total_q + CNT_W'(1);
      if ((mem[rptr] != brq.resolve_taken) && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign brq.total_cnt = total_q;
  assign brq.miss_cnt  = miss_q;
`else
  assign brq.total_cnt = '0;
  assign brq.miss_cnt  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed plus random bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  branch_resolve_queue_if #(.PTR_W(PTR_W), .CNT_W(CNT_W)) brq ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .brq   (brq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit q[$];
  int m_total = 0;
  int m_miss  = 0;
  bit e_upd, e_tk, e_mis, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic step(input bit r, input bit fl, input bit pv, input bit pb, input bit rv, input bit rt);
    bit stored;
    bit do_push;
    rst = r; flush = fl;
    brq.pred_valid = pv; brq.pred_bit = pb;
    brq.resolve_valid = rv; brq.resolve_taken = rt;
    e_upd = 0; e_mis = 0; e_err = 0;
    if (r || fl) begin
      q.delete();
      if (r) begin m_total = 0; m_miss = 0; end
    end else begin
      do_push = pv && (q.size() != DEPTH);
      e_err = rv && (q.size() == 0);
      if (rv && q.size() != 0) begin
        stored = q.pop_front();
        e_upd = 1; e_tk = rt; e_mis = (stored != rt);
        m_total++;
        if (e_mis) m_miss++;
      end
      if (do_push) q.push_back(pb);
    end
    @(posedge clk); #1;
    check("upd_valid",   brq.upd_valid,   e_upd);
    check("mispredict",  brq.mispredict,  e_mis);
    check("resolve_err", brq.resolve_err, e_err);
    check("occupancy",   brq.occupancy,   q.size());
    check("pred_ready",  brq.pred_ready,  q.size() != DEPTH);
    if (e_upd) check("upd_taken", brq.upd_taken, e_tk);
`ifdef BRQ_STATS_EN
    check("total_cnt", brq.total_cnt, sat(m_total));
    check("miss_cnt",  brq.miss_cnt,  sat(m_miss));
`else
    check("total_cnt", brq.total_cnt, 0);
    check("miss_cnt",  brq.miss_cnt,  0);
`endif
  endtask

  initial begin
    rst = 1; flush = 0;
    brq.pred_valid = 0; brq.pred_bit = 0; brq.resolve_valid = 0; brq.resolve_taken = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_upd_taken", brq.upd_taken, 0);

    // predictions 1,0,1 resolved as 1,1,0
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
`ifdef BRQ_STATS_EN
    check("seq_total", brq.total_cnt, 3);
    check("seq_miss",  brq.miss_cnt,  2);
`endif

    // overfill, then pop while full with a push that must be dropped
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, i[0], 0, 0);
    check("full_occ",   brq.occupancy,  DEPTH);
    check("full_ready", brq.pred_ready, 0);
    step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 0, 1, 1);

    // resolve on empty with same-cycle push
    step(0, 0, 1, 0, 1, 1);
    check("empty_err_occ", brq.occupancy, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);

    // flush beats push and resolve
    step(0, 1, 1, 1, 1, 0);
    check("flush_occ", brq.occupancy, 0);

    // repeated mispredicts drive both counters into saturation
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
    end
`ifdef BRQ_STATS_EN
    check("sat_total", brq.total_cnt, CNT_MAX);
    check("sat_miss",  brq.miss_cnt,  CNT_MAX);
`endif

    // reset mid-operation
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(31) == 0),
           $urandom_range(1), $urandom_range(1),
           ($urandom_range(2) == 0), $urandom_range(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
